// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control blocks.
//   intr_state_t   : interrupt controller FSM encoding
//   PC_WIDTH_DEF   : default program counter width
//   VEC_BASE_DEF   : default address of interrupt vector 0
//   VEC_STRIDE_DEF : default address distance between vectors
//   IRQ_ID_W       : width of an interrupt line index
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ENTER = 2'b01,
    ISR   = 2'b10,
    EXIT  = 2'b11
  } intr_state_t;

  localparam int                      PC_WIDTH_DEF   = 10;
  localparam logic [PC_WIDTH_DEF-1:0] VEC_BASE_DEF   = 10'h3F0;
  localparam int                      VEC_STRIDE_DEF = 2;
  localparam int                      IRQ_ID_W       = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for interrupt arbitration.
//   eligible : requests competing for service (bit 0 = highest priority)
//   winner   : index of the lowest set bit of eligible (0 when none)
//   valid    : 1 when any bit of eligible is set
module irq_prio_enc
  import cpu_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  eligible,
  output logic [IRQ_ID_W-1:0] winner,
  output logic                valid
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    winner = '0;
    valid  = |eligible;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller feeding the PC-select mux and the ALU flag-bank select.
//   clk, reset   : clock; synchronous active-low reset
//   irq          : rising-edge request lines, synchronous to clk
//   irq_mask     : per-line enable for arbitration
//   intr_en      : global enable for starting a new service
//   reti         : one-cycle return-from-interrupt strobe
//   pc_next      : next sequential PC, saved as the return address on entry
//   interrupcion : 1 while servicing (ENTER and ISR), selects shadow flags
//   take_vector  : one-cycle pulse, PC mux selects vector
//   vector       : VEC_BASE + irq_id*VEC_STRIDE, valid with take_vector
//   sel_ret      : one-cycle pulse, PC mux selects pc_ret
//   pc_ret       : saved return address (EPC), shown in every state
//   irq_ack      : one-hot pulse marking the line being entered
//   irq_id       : index of the line being / last serviced
module intr_ctrl
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
  parameter int                  NUM_IRQ    = 4,
  parameter logic [PC_WIDTH-1:0] VEC_BASE   = PC_WIDTH'(VEC_BASE_DEF),
  parameter int                  VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                intr_en,
  input  logic                reti,
  input  logic [PC_WIDTH-1:0] pc_next,
  output logic                interrupcion,
  output logic                take_vector,
  output logic [PC_WIDTH-1:0] vector,
  output logic                sel_ret,
  output logic [PC_WIDTH-1:0] pc_ret,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [2:0]          irq_id
);

  intr_state_t         state_reg;
  logic [NUM_IRQ-1:0]  irq_q_reg;
  logic [NUM_IRQ-1:0]  pending_reg;
  logic [NUM_IRQ-1:0]  pending_next;
  logic [PC_WIDTH-1:0] epc_reg;
  logic [2:0]          irq_id_reg;
  logic                interrupcion_reg;
  logic                take_vector_reg;
  logic [PC_WIDTH-1:0] vector_reg;
  logic                sel_ret_reg;
  logic [NUM_IRQ-1:0]  irq_ack_reg;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  eligible;
  logic [IRQ_ID_W-1:0] winner;
  logic                winner_valid;
  logic [NUM_IRQ-1:0]  winner_onehot;
  logic                start_entry;
  logic [PC_WIDTH-1:0] vec_calc;

  assign rise     = irq & ~irq_q_reg;
  assign eligible = pending_reg & irq_mask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .eligible (eligible),
    .winner   (winner),
    .valid    (winner_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
      assign winner_onehot[gi] = (winner == IRQ_ID_W'(gi));
    end
  endgenerate

  assign start_entry = (state_reg == IDLE) && intr_en && winner_valid;
  assign vec_calc    = VEC_BASE + PC_WIDTH'(winner) * PC_WIDTH'(VEC_STRIDE);

  // The winner's bit is cleared on entry, but a fresh edge on the same
  // line in that cycle must not be lost, so the set is OR-ed in last.
  always_comb begin
    pending_next = pending_reg;
    if (start_entry) begin
      pending_next = pending_next & ~winner_onehot;
    end
    pending_next = pending_next | rise;
  end

  // Outputs are registered on the transition into the state they belong to,
  // so each one is a clean Moore output of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      irq_q_reg        <= '0;
      pending_reg      <= '0;
      epc_reg          <= '0;
      irq_id_reg       <= '0;
      interrupcion_reg <= 1'b0;
      take_vector_reg  <= 1'b0;
      vector_reg       <= '0;
      sel_ret_reg      <= 1'b0;
      irq_ack_reg      <= '0;
    end else begin
      irq_q_reg       <= irq;
      pending_reg     <= pending_next;
      take_vector_reg <= 1'b0;
      vector_reg      <= '0;
      sel_ret_reg     <= 1'b0;
      irq_ack_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (start_entry) begin
            state_reg        <= ENTER;
            irq_id_reg       <= 3'(winner);
            epc_reg          <= pc_next;
            take_vector_reg  <= 1'b1;
            vector_reg       <= vec_calc;
            irq_ack_reg      <= winner_onehot;
            interrupcion_reg <= 1'b1;
          end
        end
        ENTER: begin
          state_reg <= ISR;
        end
        ISR: begin
          // No nesting: eligible requests simply wait in pending_reg.
          if (reti) begin
            state_reg        <= EXIT;
            sel_ret_reg      <= 1'b1;
            interrupcion_reg <= 1'b0;
          end
        end
        EXIT: begin
          // Always pass through IDLE so one main-program instruction runs.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign interrupcion = interrupcion_reg;
  assign take_vector  = take_vector_reg;
  assign vector       = vector_reg;
  assign sel_ret      = sel_ret_reg;
  assign pc_ret       = epc_reg;
  assign irq_ack      = irq_ack_reg;
  assign irq_id       = irq_id_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: reset, single request, priority,
// masking, no-nesting, level hold, spurious reti and reset mid-ISR.
module tb_intr_ctrl;

  localparam int NI = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] irq;
  logic [NI-1:0] irq_mask;
  logic          intr_en;
  logic          reti;
  logic [PW-1:0] pc_next;
  logic          interrupcion;
  logic          take_vector;
  logic [PW-1:0] vector;
  logic          sel_ret;
  logic [PW-1:0] pc_ret;
  logic [NI-1:0] irq_ack;
  logic [2:0]    irq_id;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  intr_ctrl #(
    .PC_WIDTH   (PW),
    .NUM_IRQ    (NI),
    .VEC_BASE   (10'h3F0),
    .VEC_STRIDE (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .intr_en      (intr_en),
    .reti         (reti),
    .pc_next      (pc_next),
    .interrupcion (interrupcion),
    .take_vector  (take_vector),
    .vector       (vector),
    .sel_ret      (sel_ret),
    .pc_ret       (pc_ret),
    .irq_ack      (irq_ack),
    .irq_id       (irq_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  int acks;
  int tv_seen;
  logic [NI-1:0] last_ack;
  logic reti_done;

  initial begin
    reset    = 1'b0;
    irq      = '0;
    irq_mask = 4'hF;
    intr_en  = 1'b1;
    reti     = 1'b0;
    pc_next  = 10'h045;

    // Reset: all outputs zero while reset is held.
    step();
    step();
    chk("rst_interrupcion", 32'(interrupcion), 32'h0);
    chk("rst_take_vector",  32'(take_vector),  32'h0);
    chk("rst_sel_ret",      32'(sel_ret),      32'h0);
    chk("rst_pc_ret",       32'(pc_ret),       32'h0);
    chk("rst_irq_ack",      32'(irq_ack),      32'h0);
    chk("rst_irq_id",       32'(irq_id),       32'h0);
    chk("rst_vector",       32'(vector),       32'h0);
    reset = 1'b1;
    $display("cycle %0d: reset released", cyc);

    // 1. Single request on line 2 at cycle 5.
    step(); step(); step();                 // cycle 5
    irq = 4'b0100;
    step();                                 // cycle 6: pending only
    chk("t1_no_early_vector", 32'(take_vector), 32'h0);
    step();                                 // cycle 7: ENTER
    chk("t1_take_vector",  32'(take_vector),  32'h1);
    chk("t1_vector",       32'(vector),       32'h3F4);
    chk("t1_irq_ack",      32'(irq_ack),      32'h4);
    chk("t1_interrupcion", 32'(interrupcion), 32'h1);
    chk("t1_irq_id",       32'(irq_id),       32'h2);
    chk("t1_pc_ret_saved", 32'(pc_ret),       32'h045);
    step();                                 // cycle 8: ISR
    chk("t1_tv_pulse_end", 32'(take_vector),  32'h0);
    chk("t1_ack_pulse_end",32'(irq_ack),      32'h0);
    chk("t1_isr_intr",     32'(interrupcion), 32'h1);
    step(); step(); step(); step();         // cycle 12
    reti = 1'b1;
    step();                                 // cycle 13: EXIT
    reti = 1'b0;
    chk("t1_sel_ret",      32'(sel_ret),      32'h1);
    chk("t1_pc_ret",       32'(pc_ret),       32'h045);
    chk("t1_exit_intr",    32'(interrupcion), 32'h0);
    step();                                 // IDLE
    chk("t1_sel_ret_end",  32'(sel_ret),      32'h0);
    $display("cycle %0d: line 2 serviced, return 0x045", cyc);
    irq = '0;
    step(); step();

    // 2. Lines 1 and 3 rise together; line 1 first.
    pc_next = 10'h100;
    irq = 4'b1010;
    step();
    step();                                 // ENTER line 1
    chk("t2_tv1",      32'(take_vector), 32'h1);
    chk("t2_vector1",  32'(vector),      32'h3F2);
    chk("t2_ack1",     32'(irq_ack),     32'h2);
    step();                                 // ISR
    reti = 1'b1;
    pc_next = 10'h200;
    step();                                 // EXIT
    reti = 1'b0;
    chk("t2_sel_ret1", 32'(sel_ret),     32'h1);
    chk("t2_pc_ret1",  32'(pc_ret),      32'h100);
    step();                                 // IDLE gap
    chk("t2_idle_gap", 32'(take_vector), 32'h0);
    chk("t2_gap_intr", 32'(interrupcion),32'h0);
    step();                                 // ENTER line 3
    chk("t2_tv3",      32'(take_vector), 32'h1);
    chk("t2_vector3",  32'(vector),      32'h3F6);
    chk("t2_ack3",     32'(irq_ack),     32'h8);
    chk("t2_id3",      32'(irq_id),      32'h3);
    step();
    reti = 1'b1;
    step();                                 // EXIT
    reti = 1'b0;
    chk("t2_pc_ret3",  32'(pc_ret),      32'h200);
    $display("cycle %0d: lines 1 then 3 serviced", cyc);
    irq = '0;
    step(); step();

    // 3. Masked line 0 waits until unmasked.
    irq_mask = 4'hE;
    irq = 4'b0001;
    tv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (take_vector) tv_seen++;
    end
    chk("t3_masked_no_tv", 32'(tv_seen), 32'h0);
    irq_mask = 4'hF;
    step();
    chk("t3_tv",     32'(take_vector), 32'h1);
    chk("t3_vector", 32'(vector),      32'h3F0);
    chk("t3_ack",    32'(irq_ack),     32'h1);
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t3_sel_ret", 32'(sel_ret), 32'h1);
    $display("cycle %0d: line 0 serviced after unmask", cyc);
    irq = '0;
    step(); step();

    // 4. No nesting: line 0 rises during line 2's ISR.
    irq = 4'b0100;
    step();
    step();                                 // ENTER line 2
    chk("t4_tv2", 32'(vector), 32'h3F4);
    step();                                 // ISR
    irq = 4'b0101;
    tv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (take_vector || !interrupcion) tv_seen++;
    end
    chk("t4_no_nesting", 32'(tv_seen), 32'h0);
    reti = 1'b1;
    step();                                 // EXIT
    reti = 1'b0;
    chk("t4_sel_ret",   32'(sel_ret),      32'h1);
    chk("t4_exit_intr", 32'(interrupcion), 32'h0);
    step();                                 // IDLE
    chk("t4_idle_gap",  32'(take_vector),  32'h0);
    step();                                 // ENTER line 0
    chk("t4_tv0",     32'(take_vector), 32'h1);
    chk("t4_vector0", 32'(vector),      32'h3F0);
    chk("t4_id0",     32'(irq_id),      32'h0);
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    $display("cycle %0d: deferred line 0 serviced", cyc);
    irq = '0;
    step(); step();

    // 5. Level held 20 cycles gives one entry; spurious reti in IDLE.
    irq = 4'b0010;
    pc_next = 10'h0AA;
    acks = 0;
    last_ack = '0;
    reti_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      reti = 1'b0;
      if (irq_ack != '0) begin
        acks++;
        last_ack = irq_ack;
      end
      if (interrupcion && !take_vector && !reti_done) begin
        reti = 1'b1;
        reti_done = 1'b1;
      end
    end
    reti = 1'b0;
    chk("t5_one_ack",   32'(acks),     32'h1);
    chk("t5_ack_value", 32'(last_ack), 32'h2);
    irq = '0;
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t5_spurious_sel_ret", 32'(sel_ret),       32'h0);
    chk("t5_spurious_intr",    32'(interrupcion),  32'h0);
    chk("t5_state_idle",       32'(dut.state_reg), 32'h0);
    chk("t5_pc_ret_kept",      32'(pc_ret),        32'h0AA);
    $display("cycle %0d: level hold and spurious reti done", cyc);
    step();

    // 6. Reset mid-ISR.
    pc_next = 10'h155;
    irq = 4'b0100;
    step();
    step();                                 // ENTER
    step();                                 // ISR
    irq = 4'b0101;
    step();                                 // line 0 now pending
    chk("t6_in_isr", 32'(interrupcion), 32'h1);
    reset = 1'b0;
    irq = '0;
    step();
    reset = 1'b1;
    chk("t6_intr",    32'(interrupcion),    32'h0);
    chk("t6_pc_ret",  32'(pc_ret),          32'h0);
    chk("t6_pending", 32'(dut.pending_reg), 32'h0);
    chk("t6_state",   32'(dut.state_reg),   32'h0);
    tv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (take_vector || interrupcion || sel_ret) tv_seen++;
    end
    chk("t6_no_resume", 32'(tv_seen), 32'h0);
    $display("cycle %0d: reset mid-ISR done", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that sits directly upstream of the ALU and PC-select logic in the single-cycle CPU.
- Edge-detects external request lines, latches them as pending, and arbitrates among them by fixed priority.
- On entry it redirects fetch to a vector address and saves the return PC. While servicing, it drives `interrupcion`, which steers the ALU's carry/zero flag updates into the interrupt shadow flags (`carry_intr`/`zero_intr`).
- On `reti` it restores the saved PC and returns flag updates to the main flags.

Parameters:
- PC_WIDTH, 10, width of program counter / vector / return address
- NUM_IRQ, 4, number of external interrupt request lines (1..8)
- VEC_BASE, 10'h3F0, address of vector 0
- VEC_STRIDE, 2, address distance between consecutive vectors

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge
- irq  in  NUM_IRQ  external request lines, rising-edge sensitive, synchronous to clk
- irq_mask  in  NUM_IRQ  1 = line enabled for arbitration (from control register)
- intr_en  in  1  global interrupt enable
- reti  in  1  decoded return-from-interrupt instruction, valid for one cycle
- pc_next  in  PC_WIDTH  address of next sequential instruction, saved as return PC
- interrupcion  out  1  1 while servicing, to the ALU flag-bank select
- take_vector  out  1  one-cycle pulse: PC mux selects vector
- vector  out  PC_WIDTH  target address, valid when take_vector=1
- sel_ret  out  1  one-cycle pulse: PC mux selects pc_ret
- pc_ret  out  PC_WIDTH  saved return address (EPC)
- irq_ack  out  NUM_IRQ  one-hot pulse marking the line being entered
- irq_id  out  3  index of line being / last serviced

Behaviour:

Reset values:
- Reset (reset=0 at an edge) clears irq_q, pending, epc, irq_id and the state (IDLE).
- All outputs are 0 during and after reset.
- Reset asserted mid-ISR aborts the service immediately; there is no return.

Edge detection:
- irq_q <= irq every cycle.
- rise = irq & ~irq_q.
- pending[i] <= 1 on the edge after rise[i]=1.
- A level held high produces exactly one pending event.

Pending register:
- pending is cleared only for the line being entered (ENTER transition).
- If a set and a clear of the same bit occur in the same cycle, the set wins.
- Masked lines stay pending and become eligible when unmasked.

Arbitration:
- eligible = pending & irq_mask.
- The winner is the lowest index set in eligible.

State machine (registered state, Moore outputs):
- IDLE:
  - If intr_en=1 and eligible != 0: go to ENTER; latch irq_id <= winner, epc <= pc_next, clear pending[winner].
  - Otherwise stay in IDLE.
- ENTER (1 cycle):
  - Outputs: take_vector=1, vector = VEC_BASE + irq_id*VEC_STRIDE (truncated to PC_WIDTH, wrap allowed), irq_ack = one-hot(irq_id), interrupcion=1.
  - Next state: ISR.
- ISR:
  - Outputs: interrupcion=1.
  - reti=1 → EXIT.
  - New edges are still latched as pending.
  - No nesting: eligible requests wait.
- EXIT (1 cycle):
  - Outputs: sel_ret=1, pc_ret=epc, interrupcion=0.
  - Next state: IDLE unconditionally.
  - This guarantees at least one main-program instruction executes between back-to-back interrupts.

Other rules:
- pc_ret continuously shows epc in every state.
- reti in IDLE or ENTER is ignored.
- intr_en=0 blocks only IDLE→ENTER; an ongoing ISR completes normally.
- Latency: irq rising at edge t → pending at t+1 → ENTER at t+2 → vector fetch in that cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (IDLE=2'b00, ENTER=2'b01, ISR=2'b10, EXIT=2'b11)
  - VEC_BASE and VEC_STRIDE defaults
  - PC_WIDTH default
- One sub-module, irq_prio_enc: purely combinational; input NUM_IRQ-bit eligible vector; outputs winner index (3 bits) and a valid bit.
- Edge detect, pending register and FSM stay in intr_ctrl.

Test Plan:
1. Reset then single request: irq[2] 0→1 at cycle 5, mask=4'hF, intr_en=1, pc_next=10'h045 → take_vector at cycle 7, vector=10'h3F4, irq_ack=4'b0100, interrupcion=1 from cycle 7; reti at cycle 12 → sel_ret at cycle 13 with pc_ret=10'h045, interrupcion=0.
2. Priority: irq[1] and irq[3] rise in the same cycle → line 1 serviced first (vector 10'h3F2). After its EXIT and one IDLE cycle, line 3 enters (vector 10'h3F6).
3. Masking: irq[0] rises with mask=4'hE → no take_vector; set mask=4'hF ten cycles later → ENTER one cycle after the mask change, vector=10'h3F0.
4. No nesting plus latch during ISR: irq[0] rises while in ISR for line 2 → interrupcion stays 1, no take_vector; after reti, line 0 enters two cycles after EXIT.
5. Level hold and spurious reti: irq[1] held high 20 cycles → exactly one irq_ack pulse; reti pulsed in IDLE → no sel_ret, state unchanged.
6. Reset mid-ISR: reset=0 for one edge while in ISR → next cycle interrupcion=0, pending=0, pc_ret=0, and the FSM is in IDLE.
